uart_tx_scheduler: RTL



---
 rtl/uart_tx_scheduler.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ debounced button requesters.
// Optional auto-repeat of held buttons: define UART_TX_SCHED_AUTO_REPEAT_EN.
module uart_tx_scheduler #(
  parameter int N_REQ         = 4,
  parameter int ACK_TIMEOUT   = 16,
  parameter int GAP_CYCLES    = 0,
  parameter int REPEAT_CYCLES = 50000000,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_level,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic               tx_busy,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic [ID_W-1:0]    grant_id,
  output logic [N_REQ-1:0]   pending,
  output logic [N_REQ-1:0]   overrun,
  output logic               err_timeout
);

  localparam int CNT_MAX_AG = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_AG > REPEAT_CYCLES) ? CNT_MAX_AG : REPEAT_CYCLES;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] overrun_q, overrun_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             err_timeout_q, err_timeout_d;

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] rep_set;
  logic [N_REQ-1:0] grant_clr;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  cand;
  logic             win_found;
  logic [7:0]       req_byte [N_REQ];

  assign rise = req_level & ~req_q;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_byte[i] = req_data[8*i +: 8];
  end

  // First pending index at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win_id    = rr_ptr_q;
    win_found = 1'b0;
    cand      = '0;
    for (int j = 0; j < N_REQ; j++) begin
      cand = ID_W'((int'(rr_ptr_q) + j) % N_REQ);
      if (!win_found && pending_q[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

`ifdef UART_TX_SCHED_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] hold_q [N_REQ];
  logic [CNT_W-1:0] hold_d [N_REQ];

  // Hold counters only run while the button is held and nothing is queued for it.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      hold_d[i]  = hold_q[i];
      rep_set[i] = 1'b0;
      if (!req_level[i] || rise[i]) begin
        hold_d[i] = '0;
      end else if (!pending_q[i]) begin
        if (hold_q[i] == REP_LAST) begin
          rep_set[i] = 1'b1;
          hold_d[i]  = '0;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  assign rep_set = '0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tx_start_d    = 1'b0;
    err_timeout_d = 1'b0;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    grant_clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_id_d        = win_id;
          tx_data_d         = req_byte[win_id];
          grant_clr[win_id] = 1'b1;
          rr_ptr_d          = (win_id == ID_LAST) ? '0 : win_id + 1'b1;
          tx_start_d        = 1'b1;
          cnt_d             = '0;
          state_d           = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == ACK_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_CYCLES > 0) begin
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new set on the same cycle as its grant keeps the bit pending.
  assign pending_d = (pending_q & ~grant_clr) | rise | rep_set;
  assign overrun_d = overrun_q | (rise & pending_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_q         <= '0;
      pending_q     <= '0;
      overrun_q     <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_level;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign pending     = pending_q;
  assign overrun     = overrun_q;
  assign err_timeout = err_timeout_q;

endmodule
